// File: rtl/div_seq_unit_pkg.sv
// div_seq_unit_pkg: shared op/state types, iteration counts and two's-complement helper
package div_seq_unit_pkg;
    typedef enum logic [2:0] {
        OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
    } div_op_t;
    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} div_state_t;
    localparam logic [6:0] DIV_ITER_64 = 7'd64;
    localparam logic [6:0] DIV_ITER_32 = 7'd32;
    function automatic logic [63:0] twos_comp_64(input logic [63:0] a);
        return ~a + 64'd1;
    endfunction
endpackage

// File: rtl/div_iter_step.sv
// div_iter_step: one radix-2 restoring step on the {rem, quo} pair
module div_iter_step (
    input  logic [63:0] rem,
    input  logic [63:0] quo,
    input  logic [63:0] dvs,
    output logic [63:0] rem_nxt,
    output logic [63:0] quo_nxt
);
    logic [64:0] sh, diff;
    always_comb begin
        // 65 bits: the shifted remainder can exceed 2^64 - 1 before the trial subtract
        sh = {rem, quo[63]};
        diff = sh - {1'b0, dvs};
        rem_nxt = diff[64] ? sh[63:0] : diff[63:0];
        quo_nxt = {quo[62:0], ~diff[64]};
    end
endmodule

// File: rtl/div_seq_unit.sv
// div_seq_unit: iterative RV64M DIV/REM sequencer with valid/ready handshake and flush
module div_seq_unit
    import div_seq_unit_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    div_state_t state, nxt;
    div_op_t op;
    logic [63:0] a, b, rem, quo, dvs, rem_nxt, quo_nxt;
    logic [63:0] ea, eb, ma, mb, ovf_min, zero_res, ovf_res, qf, rf, sel;
    logic [6:0] cnt;
    logic q_neg, r_neg, w, sgn, is_rem, sa, sb, dz, ovf;
    // op encoding: bit2 = W variant, bit1 = remainder, bit0 = unsigned
    always_comb begin
        w = op[2];
        is_rem = op[1];
        sgn = !op[0];
        ea = w ? {{32{sgn & a[31]}}, a[31:0]} : a;
        eb = w ? {{32{sgn & b[31]}}, b[31:0]} : b;
        sa = sgn & ea[63];
        sb = sgn & eb[63];
        ma = sa ? twos_comp_64(ea) : ea;
        mb = sb ? twos_comp_64(eb) : eb;
        dz = eb == 64'd0;
        ovf_min = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        ovf = sgn && ea == ovf_min && &eb;
        zero_res = is_rem ? (w ? {{32{a[31]}}, a[31:0]} : a) : '1;
        ovf_res = is_rem ? 64'd0 : ea;
        qf = q_neg ? twos_comp_64(quo) : quo;
        rf = r_neg ? twos_comp_64(rem) : rem;
        sel = is_rem ? rf : qf;
    end
    div_iter_step u_step (
        .rem(rem), .quo(quo), .dvs(dvs), .rem_nxt(rem_nxt), .quo_nxt(quo_nxt)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else state <= nxt;
    always_comb
        nxt = flush ? S_IDLE :
              state == S_IDLE ? (in_valid ? S_PREP : S_IDLE) :
              state == S_PREP ? (dz || ovf ? S_DONE : S_CALC) :
              state == S_CALC ? (cnt == 7'd1 ? S_FIX : S_CALC) :
              state == S_FIX  ? S_DONE :
              out_ready ? S_IDLE : S_DONE;
    always_comb begin
        out_valid = state == S_DONE;
        busy = state != S_IDLE;
        in_ready = state == S_IDLE && !flush;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            op <= OP_DIV;
            a <= '0;
            b <= '0;
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            cnt <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            out_result <= '0;
            out_tag <= '0;
        end else begin
            if (state == S_IDLE && in_valid && !flush) begin
                op <= div_op_t'(in_op);
                a <= in_rs1;
                b <= in_rs2;
                out_tag <= in_tag;
            end
            if (state == S_PREP) begin
                rem <= '0;
                // W ops park the 32-bit dividend high so 32 steps leave the quotient in the low half
                quo <= w ? {ma[31:0], 32'd0} : ma;
                dvs <= mb;
                cnt <= w ? DIV_ITER_32 : DIV_ITER_64;
                q_neg <= sa ^ sb;
                r_neg <= sa;
                if (dz) out_result <= zero_res;
                else if (ovf) out_result <= ovf_res;
            end
            if (state == S_CALC) begin
                rem <= rem_nxt;
                quo <= quo_nxt;
                cnt <= cnt - 7'd1;
            end
            if (state == S_FIX) out_result <= w ? {{32{sel[31]}}, sel[31:0]} : sel;
        end
endmodule

// File: tb/tb_div_seq_unit.sv
// tb_div_seq_unit: directed self-checking bench for div_seq_unit
module tb_div_seq_unit;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, busy;
    logic [2:0] in_op = 3'd0;
    logic [63:0] in_rs1 = '0, in_rs2 = '0, out_result;
    logic [4:0] in_tag = '0, out_tag;
    int checks = 0, errors = 0;

    div_seq_unit #(.XLEN(64), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [63:0] ra,
                          input logic [63:0] rb, input logic [4:0] t,
                          input logic [63:0] exp, input int lat, input int hold);
        int n;
        logic [63:0] r0;
        in_valid = 1'b1;
        in_op = op;
        in_rs1 = ra;
        in_rs2 = rb;
        in_tag = t;
        check({name, " in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        check({name, " latency"}, n, lat);
        check({name, " result"}, out_result, exp);
        check({name, " tag"}, out_tag, t);
        if (hold > 0) begin
            r0 = out_result;
            for (int i = 0; i < hold; i++) tick();
            check({name, " hold valid"}, out_valid, 1);
            check({name, " hold result"}, out_result, r0);
            check({name, " hold tag"}, out_tag, t);
            check({name, " hold in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " busy after"}, busy, 0);
        check({name, " in_ready after"}, in_ready, 1);
    endtask

    initial begin
        logic seen;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst out_valid", out_valid, 0);
        check("rst out_result", out_result, 0);
        check("rst out_tag", out_tag, 0);
        check("rst busy", busy, 0);
        check("rst in_ready", in_ready, 1);
        tick();
        run_op("div", 3'd0, -64'sd20, 64'd3, 5'd1, 64'hFFFF_FFFF_FFFF_FFFA, 67, 10);
        run_op("rem", 3'd2, -64'sd20, 64'd3, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 67, 0);
        run_op("divu", 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64'h7FFF_FFFF_FFFF_FFFF, 67, 0);
        run_op("remuw", 3'd7, 64'h1_0000_0007, 64'd4, 5'd4, 64'd3, 35, 0);
        run_op("div0", 3'd0, 64'd42, 64'd0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
        run_op("rem0", 3'd2, 64'd42, 64'd0, 5'd6, 64'd42, 2, 0);
        run_op("divw ovf", 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 5'd7, 64'hFFFF_FFFF_8000_0000, 2, 0);
        run_op("div ovf", 3'd0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8,
               64'h8000_0000_0000_0000, 2, 0);
        run_op("remw", 3'd6, 64'hFFFF_FFF9, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 35, 0);
        run_op("divuw", 3'd5, 64'hFFFF_FFFE, 64'd1, 5'd10, 64'hFFFF_FFFF_FFFF_FFFE, 35, 0);
        // request coincident with flush must be refused
        flush = 1'b1;
        in_valid = 1'b1;
        in_op = 3'd1;
        in_rs1 = 64'd5;
        in_rs2 = 64'd1;
        #1;
        check("flush in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush no accept", busy, 0);
        // flush mid-CALC
        in_valid = 1'b1;
        in_op = 3'd1;
        in_rs1 = 64'd1000;
        in_rs2 = 64'd3;
        in_tag = 5'd11;
        tick();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 1; i < 31; i++) begin
            seen |= out_valid;
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", busy, 0);
        check("flush out_valid", out_valid, 0);
        for (int i = 0; i < 70; i++) begin
            seen |= out_valid;
            tick();
        end
        check("flush never valid", seen, 0);
        run_op("divu post flush", 3'd1, 64'd100, 64'd7, 5'd12, 64'd14, 67, 0);
        // async reset mid-CALC
        in_valid = 1'b1;
        in_op = 3'd0;
        in_rs1 = 64'd1000;
        in_rs2 = 64'd7;
        in_tag = 5'd13;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 40; i++) tick();
        check("pre-rst busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid rst out_valid", out_valid, 0);
        check("mid rst out_result", out_result, 0);
        check("mid rst out_tag", out_tag, 0);
        check("mid rst busy", busy, 0);
        tick();
        rst = 1'b0;
        #1;
        check("post rst in_ready", in_ready, 1);
        tick();
        run_op("divuw post rst", 3'd5, 64'd9, 64'd2, 5'd14, 64'd4, 35, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
